// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic edge feeder.
// Holds the feeder FSM encoding plus constant helpers for lane sizing and slicing.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } feeder_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Low bit of lane `lane` in a flat bus of `width`-bit lanes.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Per-lane {valid,data} delay line: DEPTH+1 register stages, so output lags input by DEPTH+1 cycles.
// Never stalls; data only moves with valid, flush clears the valid bits and keeps the data.
module skew_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             dly_valid,
  output logic [WIDTH-1:0] dly_data
);

  logic [DEPTH:0]   vld;
  logic [WIDTH-1:0] dat [DEPTH+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int k = 0; k <= DEPTH; k++) dat[k] <= '0;
    end else if (flush) begin
      vld <= '0;
    end else begin
      vld[0] <= src_valid;
      if (src_valid) dat[0] <= src_data;
      for (int k = 1; k <= DEPTH; k++) begin
        vld[k] <= vld[k-1];
        if (vld[k-1]) dat[k] <= dat[k-1];
      end
    end
  end

  assign dly_valid = vld[DEPTH];
  assign dly_data  = dat[DEPTH];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Skews A/B beats into the diagonal wavefront for the PE grid; lane i appears 1+i cycles after acceptance.
// No output backpressure; in_ready drops during DRAIN/DONE. SKEW_FEEDER_STATS_EN adds bubble_cnt.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int INPUT_WIDTH   = 8,
  parameter int NUM_ROWS      = 4,
  parameter int NUM_COLS      = 4,
  parameter int VECTOR_LENGTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clear,
  input  logic [NUM_ROWS*INPUT_WIDTH-1:0] in_a,
  input  logic [NUM_COLS*INPUT_WIDTH-1:0] in_b,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [NUM_ROWS*INPUT_WIDTH-1:0] a_edge,
  output logic [NUM_ROWS-1:0]             a_edge_valid,
  output logic [NUM_COLS*INPUT_WIDTH-1:0] b_edge,
  output logic [NUM_COLS-1:0]             b_edge_valid,
  output logic                            busy,
`ifdef SKEW_FEEDER_STATS_EN
  output logic [15:0]                     bubble_cnt,
`endif
  output logic                            tile_done
);

  localparam int MAX_LANES = max_int(NUM_ROWS, NUM_COLS);
  localparam int BEAT_W    = $clog2(VECTOR_LENGTH + 1);
  localparam int DRAIN_W   = (MAX_LANES > 1) ? $clog2(MAX_LANES) : 1;
  localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(VECTOR_LENGTH);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((MAX_LANES > 1) ? MAX_LANES - 2 : 0);

  feeder_state_t      state;
  logic [BEAT_W-1:0]  beat_cnt;
  logic [BEAT_W-1:0]  beat_inc;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               accept;
  logic               lane_valid;

  assign in_ready   = (state == IDLE) || (state == FEED);
  assign busy       = (state != IDLE);
  assign accept     = in_valid && in_ready;
  // A beat coinciding with clear is dropped so the flushed array sees nothing.
  assign lane_valid = accept && !clear;
  assign beat_inc   = (beat_cnt == BEAT_LAST) ? beat_cnt : beat_cnt + BEAT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      tile_done <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      tile_done <= 1'b0;
    end else begin
      tile_done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            beat_cnt  <= BEAT_W'(1);
            drain_cnt <= '0;
            if (VECTOR_LENGTH == 1) begin
              if (MAX_LANES > 1) begin
                state <= DRAIN;
              end else begin
                state     <= DONE;
                tile_done <= 1'b1;
              end
            end else begin
              state <= FEED;
            end
          end
        end
        FEED: begin
          if (in_valid) begin
            beat_cnt <= beat_inc;
            if (beat_inc == BEAT_LAST) begin
              drain_cnt <= '0;
              if (MAX_LANES > 1) begin
                state <= DRAIN;
              end else begin
                state     <= DONE;
                tile_done <= 1'b1;
              end
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state     <= DONE;
            tile_done <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DRAIN_W'(1);
          end
        end
        DONE: begin
          state     <= IDLE;
          beat_cnt  <= '0;
          drain_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SKEW_FEEDER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (clear || (state == IDLE && in_valid)) begin
      bubble_cnt <= '0;
    end else if (state == FEED && !in_valid && bubble_cnt != 16'hFFFF) begin
      bubble_cnt <= bubble_cnt + 16'd1;
    end
  end
`endif

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    skew_delay_line #(
      .WIDTH (INPUT_WIDTH),
      .DEPTH (r)
    ) u_dly (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (clear),
      .src_valid (lane_valid),
      .src_data  (in_a[lane_lo(r, INPUT_WIDTH) +: INPUT_WIDTH]),
      .dly_valid (a_edge_valid[r]),
      .dly_data  (a_edge[lane_lo(r, INPUT_WIDTH) +: INPUT_WIDTH])
    );
  end

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    skew_delay_line #(
      .WIDTH (INPUT_WIDTH),
      .DEPTH (c)
    ) u_dly (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (clear),
      .src_valid (lane_valid),
      .src_data  (in_b[lane_lo(c, INPUT_WIDTH) +: INPUT_WIDTH]),
      .dly_valid (b_edge_valid[c]),
      .dly_data  (b_edge[lane_lo(c, INPUT_WIDTH) +: INPUT_WIDTH])
    );
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder: 4x4 table-driven tiles plus a 2x5 instance.
// Honours SKEW_FEEDER_STATS_EN for the bubble counter port.
module tb_systolic_skew_feeder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear, in_valid, in_ready, busy, tile_done;
  logic [31:0] in_a, in_b, a_edge, b_edge;
  logic [3:0]  a_edge_valid, b_edge_valid;

  logic        clear2, in_valid2, in_ready2, busy2, tile_done2;
  logic [15:0] in_a2, a_edge2;
  logic [39:0] in_b2, b_edge2;
  logic [1:0]  a_edge_valid2;
  logic [4:0]  b_edge_valid2;
`ifdef SKEW_FEEDER_STATS_EN
  logic [15:0] bubble_cnt, bubble_cnt2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  systolic_skew_feeder dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_a(in_a), .in_b(in_b),
    .in_valid(in_valid), .in_ready(in_ready), .a_edge(a_edge),
    .a_edge_valid(a_edge_valid), .b_edge(b_edge), .b_edge_valid(b_edge_valid),
    .busy(busy),
`ifdef SKEW_FEEDER_STATS_EN
    .bubble_cnt(bubble_cnt),
`endif
    .tile_done(tile_done)
  );

  systolic_skew_feeder #(.INPUT_WIDTH(8), .NUM_ROWS(2), .NUM_COLS(5), .VECTOR_LENGTH(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clear2), .in_a(in_a2), .in_b(in_b2),
    .in_valid(in_valid2), .in_ready(in_ready2), .a_edge(a_edge2),
    .a_edge_valid(a_edge_valid2), .b_edge(b_edge2), .b_edge_valid(b_edge_valid2),
    .busy(busy2),
`ifdef SKEW_FEEDER_STATS_EN
    .bubble_cnt(bubble_cnt2),
`endif
    .tile_done(tile_done2)
  );

  typedef struct {
    logic        vld;
    logic        clr;
    logic [7:0]  beat;
    logic        ready;
    logic [3:0]  ev;
    logic        busy;
    logic        done;
    logic [31:0] edge_dat;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic add(input logic vld, input logic clr, input logic [7:0] beat, input logic ready,
                     input logic [3:0] ev, input logic bsy, input logic done, input logic [31:0] e);
    vec_t v;
    v.vld = vld; v.clr = clr; v.beat = beat; v.ready = ready;
    v.ev = ev; v.busy = bsy; v.done = done; v.edge_dat = e;
    vt.push_back(v);
  endtask

  // Each entry is one cycle: inputs held for the cycle, outputs sampled on the falling edge.
  task automatic run_table(input string tag);
    for (int i = 0; i < vt.size(); i++) begin
      in_valid = vt[i].vld;
      clear    = vt[i].clr;
      in_a     = {4{vt[i].beat}};
      in_b     = {4{vt[i].beat}};
      @(negedge clk);
      check($sformatf("%s[%0d] in_ready", tag, i), in_ready, vt[i].ready);
      check($sformatf("%s[%0d] a_valid", tag, i), a_edge_valid, vt[i].ev);
      check($sformatf("%s[%0d] b_valid", tag, i), b_edge_valid, vt[i].ev);
      check($sformatf("%s[%0d] busy", tag, i), busy, vt[i].busy);
      check($sformatf("%s[%0d] tile_done", tag, i), tile_done, vt[i].done);
      check($sformatf("%s[%0d] a_edge", tag, i), a_edge, vt[i].edge_dat);
      check($sformatf("%s[%0d] b_edge", tag, i), b_edge, vt[i].edge_dat);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    clear    = 1'b0;
    vt.delete();
  endtask

  task automatic fill_single();
    add(1, 0, 8'd1, 1, 4'h0, 0, 0, 32'h00000000);
    add(1, 0, 8'd2, 1, 4'h1, 1, 0, 32'h00000001);
    add(1, 0, 8'd3, 1, 4'h3, 1, 0, 32'h00000102);
    add(1, 0, 8'd4, 1, 4'h7, 1, 0, 32'h00010203);
    add(0, 0, 8'd0, 0, 4'hF, 1, 0, 32'h01020304);
    add(0, 0, 8'd0, 0, 4'hE, 1, 0, 32'h02030404);
    add(0, 0, 8'd0, 0, 4'hC, 1, 0, 32'h03040404);
    add(0, 0, 8'd0, 0, 4'h8, 1, 1, 32'h04040404);
    add(0, 0, 8'd0, 1, 4'h0, 0, 0, 32'h04040404);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    clear2 = 1'b0; in_valid2 = 1'b0; in_a2 = '0; in_b2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst a_valid", a_edge_valid, 4'h0);
    check("rst b_valid", b_edge_valid, 4'h0);
    check("rst a_edge", a_edge, 32'h0);
    check("rst busy", busy, 1'b0);
    check("rst tile_done", tile_done, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    fill_single();
    run_table("single");

    // Bubble in cycle 1: every lane shows one empty slot, tile_done one cycle later.
    do_reset();
    add(1, 0, 8'd1, 1, 4'h0, 0, 0, 32'h00000000);
    add(0, 0, 8'd0, 1, 4'h1, 1, 0, 32'h00000001);
    add(1, 0, 8'd2, 1, 4'h2, 1, 0, 32'h00000101);
    add(1, 0, 8'd3, 1, 4'h5, 1, 0, 32'h00010102);
    add(1, 0, 8'd4, 1, 4'hB, 1, 0, 32'h01010203);
    add(0, 0, 8'd0, 0, 4'h7, 1, 0, 32'h01020304);
    add(0, 0, 8'd0, 0, 4'hE, 1, 0, 32'h02030404);
    add(0, 0, 8'd0, 0, 4'hC, 1, 0, 32'h03040404);
    add(0, 0, 8'd0, 0, 4'h8, 1, 1, 32'h04040404);
    add(0, 0, 8'd0, 1, 4'h0, 0, 0, 32'h04040404);
    run_table("bubble");

    // in_valid held high: beats offered during DRAIN/DONE are ignored.
    do_reset();
    add(1, 0, 8'd1, 1, 4'h0, 0, 0, 32'h00000000);
    add(1, 0, 8'd2, 1, 4'h1, 1, 0, 32'h00000001);
    add(1, 0, 8'd3, 1, 4'h3, 1, 0, 32'h00000102);
    add(1, 0, 8'd4, 1, 4'h7, 1, 0, 32'h00010203);
    add(1, 0, 8'd9, 0, 4'hF, 1, 0, 32'h01020304);
    add(1, 0, 8'd9, 0, 4'hE, 1, 0, 32'h02030404);
    add(1, 0, 8'd9, 0, 4'hC, 1, 0, 32'h03040404);
    add(1, 0, 8'd9, 0, 4'h8, 1, 1, 32'h04040404);
    add(1, 0, 8'd5, 1, 4'h0, 0, 0, 32'h04040404);
    add(1, 0, 8'd6, 1, 4'h1, 1, 0, 32'h04040405);
    run_table("b2b");

    // clear with a beat offered: beat dropped, no tile_done, then a clean tile.
    do_reset();
    add(1, 0, 8'd1, 1, 4'h0, 0, 0, 32'h00000000);
    add(1, 1, 8'd2, 1, 4'h1, 1, 0, 32'h00000001);
    for (int k = 0; k < 5; k++) add(0, 0, 8'd0, 1, 4'h0, 0, 0, 32'h00000001);
    add(1, 0, 8'd5, 1, 4'h0, 0, 0, 32'h00000001);
    add(1, 0, 8'd6, 1, 4'h1, 1, 0, 32'h00000005);
    add(1, 0, 8'd7, 1, 4'h3, 1, 0, 32'h00000506);
    add(1, 0, 8'd8, 1, 4'h7, 1, 0, 32'h00050607);
    add(0, 0, 8'd0, 0, 4'hF, 1, 0, 32'h05060708);
    add(0, 0, 8'd0, 0, 4'hE, 1, 0, 32'h06070808);
    add(0, 0, 8'd0, 0, 4'hC, 1, 0, 32'h07080808);
    add(0, 0, 8'd0, 0, 4'h8, 1, 1, 32'h08080808);
    add(0, 0, 8'd0, 1, 4'h0, 0, 0, 32'h08080808);
    run_table("clear");

    // Async reset in the middle of DRAIN, then a fresh tile.
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1; in_a = {4{8'(k)}}; in_b = {4{8'(k)}};
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst a_valid", a_edge_valid, 4'h0);
    check("midrst b_valid", b_edge_valid, 4'h0);
    check("midrst a_edge", a_edge, 32'h0);
    check("midrst b_edge", b_edge, 32'h0);
    check("midrst busy", busy, 1'b0);
    check("midrst in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    fill_single();
    run_table("after_rst");

    // Non-square 2x5: four DRAIN cycles, last column lane valid from t+5.
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      in_valid2 = (c < 4);
      in_a2 = {2{8'(c + 1)}};
      in_b2 = {5{8'(c + 1)}};
      @(negedge clk);
      check($sformatf("ns[%0d] b_valid4", c), b_edge_valid2[4], (c >= 5 && c <= 8));
      check($sformatf("ns[%0d] a_valid", c), a_edge_valid2,
            {1'(c >= 2 && c <= 5), 1'(c >= 1 && c <= 4)});
      check($sformatf("ns[%0d] in_ready", c), in_ready2, (c < 4 || c > 8));
      check($sformatf("ns[%0d] busy", c), busy2, (c >= 1 && c <= 8));
      check($sformatf("ns[%0d] tile_done", c), tile_done2, (c == 8));
      @(posedge clk); #1;
    end
    in_valid2 = 1'b0;
    check("ns b_edge lane4", b_edge2[39:32], 8'd4);

`ifdef SKEW_FEEDER_STATS_EN
    do_reset();
    in_valid = 1'b1; in_a = {4{8'd1}}; in_b = {4{8'd1}};
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check("stats bubble_cnt", bubble_cnt, 16'd3);
    @(posedge clk); #1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
